// File: rtl/layer7_pkg.sv
// Shared definitions for the layer-7 CIM macro input sequencer.
//   state_e   : sequencer states (idle, load, convert, done)
//   DATAVALID : active level of the macro data_e strobe
//   WIN_W     : flattened window width for the default geometry
package layer7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StConv,
    StDone
  } state_e;

  localparam logic DATAVALID = 1'b1;

  localparam int unsigned FM_DEPTH_DEF = 256;
  localparam int unsigned KERNEL_DEF   = 9;
  localparam int unsigned WIN_W        = FM_DEPTH_DEF / 2 * KERNEL_DEF;

endpackage

// File: rtl/win_prefetch_buf.sv
// One-entry holding register with a valid flag, used to park the next window
// while the current one is being converted.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears the flag only)
//   push_i  : capture data_i and set the flag
//   pop_i   : clear the flag (entry consumed)
//   data_i  : incoming window
//   valid_o : entry present
//   data_o  : stored window
module win_prefetch_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop_i) begin
      valid_d = 1'b0;
    end
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by the flag, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/macro_drv_layer7.sv
// Input-side sequencer for the layer-7 CIM macro array. Accepts windows over
// valid/ready, drives data_in and the latch/data_e/macro_e/adc strobes through
// LOAD (1 cycle) and CONV (CONV_CYCLES cycles), then pulses done for 1 cycle.
//   clk, rst_n            : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_data is the flattened window
//   data_in               : window presented to the macro [row][tap]
//   latch, data_e         : macro input latch / phase-counter restart strobes
//   macro_e, adc          : count enable / ADC strobe during CONV
//   done, busy, win_cnt   : window complete pulse, not-idle, completed count
module macro_drv_layer7
  import layer7_pkg::*;
#(
  parameter int unsigned FM_DEPTH    = FM_DEPTH_DEF,
  parameter int unsigned KERNEL      = KERNEL_DEF,
  parameter int unsigned CONV_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FM_DEPTH/2*KERNEL-1:0]         in_data,
  output logic [FM_DEPTH/2-1:0][KERNEL-1:0]    data_in,
  output logic                                 latch,
  output logic                                 data_e,
  output logic                                 macro_e,
  output logic                                 adc,
  output logic                                 done,
  output logic                                 busy,
  output logic [15:0]                          win_cnt
);

  localparam int unsigned WinW = FM_DEPTH / 2 * KERNEL;
  localparam int unsigned PhW  = $clog2(CONV_CYCLES);
  localparam logic [PhW-1:0] PhLast = PhW'(CONV_CYCLES - 1);

  state_e            state_d, state_q;
  logic [PhW-1:0]    ph_d, ph_q;
  logic [WinW-1:0]   hold_d, hold_q;
  logic [15:0]       win_cnt_d, win_cnt_q;
  logic              latch_d, latch_q;
  logic              data_e_d, data_e_q;
  logic              macro_e_d, macro_e_q;
  logic              adc_d, adc_q;
  logic              done_d, done_q;
  logic              busy_d, busy_q;

  logic              xfer;
  logic              pf_push, pf_pop, pf_valid;
  logic [WinW-1:0]   pf_data;

  // Ready tracks the prefetch slot in every state; forced low during reset.
  assign in_ready = ~pf_valid & ~rst_n;
  assign xfer     = in_valid & in_ready;
  // In IDLE the window bypasses the prefetch slot and goes straight to hold.
  assign pf_push  = xfer & (state_q != StIdle);

  win_prefetch_buf #(
    .Width (WinW)
  ) u_prefetch (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .push_i  (pf_push),
    .pop_i   (pf_pop),
    .data_i  (in_data),
    .valid_o (pf_valid),
    .data_o  (pf_data)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    hold_d    = hold_q;
    win_cnt_d = win_cnt_q;
    pf_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pf_valid) begin
          hold_d  = pf_data;
          pf_pop  = 1'b1;
          state_d = StLoad;
        end else if (xfer) begin
          hold_d  = in_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        ph_d    = '0;
        state_d = StConv;
      end
      StConv: begin
        ph_d = ph_q + PhW'(1);
        if (ph_q == PhLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        win_cnt_d = win_cnt_q + 16'd1;
        if (pf_valid) begin
          hold_d  = pf_data;
          pf_pop  = 1'b1;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    latch_d   = (state_d == StLoad);
    data_e_d  = (state_d == StLoad) ? DATAVALID : ~DATAVALID;
    macro_e_d = (state_d == StConv);
    adc_d     = (state_d == StConv) & ph_d[0];
    done_d    = (state_d == StDone);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= StIdle;
      ph_q      <= '0;
      hold_q    <= '0;
      win_cnt_q <= '0;
      latch_q   <= 1'b0;
      data_e_q  <= 1'b0;
      macro_e_q <= 1'b0;
      adc_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      hold_q    <= hold_d;
      win_cnt_q <= win_cnt_d;
      latch_q   <= latch_d;
      data_e_q  <= data_e_d;
      macro_e_q <= macro_e_d;
      adc_q     <= adc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign data_in = hold_q;
  assign latch   = latch_q;
  assign data_e  = data_e_q;
  assign macro_e = macro_e_q;
  assign adc     = adc_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign win_cnt = win_cnt_q;

endmodule
